// File: rtl/router_pkg.sv
// Shared types and constants for the source-side router receiver.
package router_pkg;
  localparam int DATA_W   = 8;
  localparam int LEN_W    = 6;
  localparam int ADDR_W   = 2;
  localparam int NUM_DEST = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    PARITY,
    CHECK,
    DROP
  } state_e;
endpackage

// File: rtl/router_hold_reg.sv
// One-entry hold register between the packet parser and the destination FIFOs;
// it steers the held byte to its FIFO and reports the full-flag stall.
module router_hold_reg
  import router_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [ADDR_W-1:0]   load_dest,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic                full_stall,
  output logic [NUM_DEST-1:0] fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_wdata
);

  logic              hold_vld_p1;
  logic [DATA_W-1:0] hold_data_p1;
  logic [ADDR_W-1:0] hold_dest_p1;
  logic              dest_full;
  logic              drain;

  always_comb begin
    dest_full  = 1'b0;
    fifo_wr_en = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (hold_dest_p1 == ADDR_W'(i)) dest_full = fifo_full[i];
    end
    drain      = hold_vld_p1 & ~dest_full;
    full_stall = hold_vld_p1 & dest_full;
    for (int i = 0; i < NUM_DEST; i++) begin
      fifo_wr_en[i] = drain & (hold_dest_p1 == ADDR_W'(i));
    end
    fifo_wdata = drain ? hold_data_p1 : '0;
  end

  // p1: accepted byte waits here until its FIFO has room
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_vld_p1  <= 1'b0;
      hold_dest_p1 <= '0;
    end else begin
      if (load) begin
        hold_vld_p1  <= 1'b1;
        hold_dest_p1 <= load_dest;
      end else if (drain) begin
        hold_vld_p1  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) hold_data_p1 <= load_data;
  end

endmodule

// File: rtl/router_src_rx.sv
// Source-side packet receiver: parses header/payload/parity framing, checks
// length, address and parity, and forwards valid-address bytes to one FIFO.
module router_src_rx
  import router_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pkt_valid,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic                busy,
  output logic                error,
  output logic [NUM_DEST-1:0] fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_wdata
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] dest;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] parity_acc;
  logic              len_err, addr_err, par_err;

  logic              full_stall;
  logic              payload_phase, parity_phase;
  logic              accept, hdr_acc, pay_acc, par_acc, len_flag;
  logic              hold_load;
  logic [ADDR_W-1:0] load_dest;
  logic [ADDR_W-1:0] hdr_addr;
  logic [LEN_W-1:0]  hdr_len;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];

  // DROP reuses the payload/parity rules, selected by whether bytes remain
  always_comb begin
    busy          = full_stall | (state == CHECK);
    payload_phase = (state == PAYLOAD) | ((state == DROP) & (count != '0));
    parity_phase  = (state == PARITY)  | ((state == DROP) & (count == '0));
    accept        = ~busy & (((state == IDLE) & pkt_valid) | payload_phase | parity_phase);
    hdr_acc       = accept & (state == IDLE);
    pay_acc       = accept & payload_phase & pkt_valid;
    par_acc       = accept & ((payload_phase & ~pkt_valid) | parity_phase);
    len_flag      = (payload_phase & ~pkt_valid) | (parity_phase & pkt_valid);
    hold_load     = (hdr_acc & (hdr_addr != ADDR_INVALID))
                  | (accept & ((state == PAYLOAD) | (state == PARITY)));
    load_dest     = hdr_acc ? hdr_addr : dest;
    state_n       = state;
    case (state)
      IDLE: begin
        if (hdr_acc) begin
          if (hdr_addr == ADDR_INVALID) state_n = DROP;
          else if (hdr_len == '0)       state_n = PARITY;
          else                          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (par_acc)                                  state_n = CHECK;
        else if (pay_acc && (count == LEN_W'(1)))     state_n = PARITY;
      end
      PARITY:  if (par_acc) state_n = CHECK;
      DROP:    if (par_acc) state_n = CHECK;
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // p0: per-packet bookkeeping updated on each accepted byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest       <= '0;
      count      <= '0;
      parity_acc <= '0;
      len_err    <= 1'b0;
      addr_err   <= 1'b0;
      par_err    <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (hdr_acc) begin
        dest       <= hdr_addr;
        count      <= hdr_len;
        parity_acc <= data_in;
        len_err    <= 1'b0;
        addr_err   <= (hdr_addr == ADDR_INVALID);
        par_err    <= 1'b0;
        error      <= 1'b0;
      end
      if (pay_acc) begin
        parity_acc <= parity_acc ^ data_in;
        count      <= count - LEN_W'(1);
      end
      if (par_acc) begin
        par_err <= (parity_acc != data_in);
        if (len_flag) len_err <= 1'b1;
      end
      if (state == CHECK) error <= par_err | len_err | addr_err;
    end
  end

  router_hold_reg u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .load_data  (data_in),
    .load_dest  (load_dest),
    .fifo_full  (fifo_full),
    .full_stall (full_stall),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata)
  );

endmodule
